// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock keypad front end: column drive
// patterns, frame classes, key legend codes and key-code helpers.
package alarm_pkg;

    localparam logic [3:0] COL_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_KEY   = 2'd1,
        CLS_MULTI = 2'd2
    } frame_cls_e;

    typedef struct packed {
        frame_cls_e cls;
        logic [3:0] code;
    } frame_class_t;

    localparam frame_class_t CLASS_NONE = '{cls: CLS_NONE, code: 4'd0};

    // Legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, code = row*4 + col
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    function automatic logic [3:0] key_to_digit(input logic [3:0] code);
        logic [3:0] digit;
        case (code)
            KEY_0:   digit = 4'd0;
            KEY_1:   digit = 4'd1;
            KEY_2:   digit = 4'd2;
            KEY_3:   digit = 4'd3;
            KEY_4:   digit = 4'd4;
            KEY_5:   digit = 4'd5;
            KEY_6:   digit = 4'd6;
            KEY_7:   digit = 4'd7;
            KEY_8:   digit = 4'd8;
            KEY_9:   digit = 4'd9;
            default: digit = 4'hF;
        endcase
        return digit;
    endfunction

    // Frame bit col*4+row holds key row*4+col, so the code is the index with
    // its two halves swapped. MULTI carries code 0 so all MULTI frames compare equal.
    function automatic frame_class_t classify_frame(input logic [15:0] frame);
        frame_class_t res;
        logic [4:0]   ones;
        logic [3:0]   idx;
        ones     = 5'd0;
        res.code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            if (frame[i]) begin
                ones     = ones + 5'd1;
                res.code = {idx[1:0], idx[3:2]};
            end else begin
                ones = ones;
            end
        end
        if (ones == 5'd0) begin
            res.cls = CLS_NONE;
        end else if (ones == 5'd1) begin
            res.cls = CLS_KEY;
        end else begin
            res.cls  = CLS_MULTI;
            res.code = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event bundle between the scanner and the clock logic.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row_n, output col_n, output key_code, output key_valid, output key_held);
    modport slave  (output row_n, input col_n, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider: one-cycle tick every CYCLES clocks, aligned to the
// last count of each period.
module scan_tick_gen #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count_r;

    // Tick is registered one count early so it is high while count_r is at its final value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            tick    <= 1'b0;
        end else begin
            if (count_r == CW'(CYCLES - 1)) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
            tick <= (count_r == CW'(CYCLES - 2));
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column per slot, whole-frame
// debounce, one-cycle strobe per accepted key press.
module keypad_scanner
    import alarm_pkg::*;
#(
    parameter int unsigned SCAN_TICK_CYC   = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 20
) (
    input logic               clk,
    input logic               rst,
    keypad_scanner_if.master  bus
);
    localparam int unsigned SW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [3:0]    row_meta_r;
    logic [3:0]    row_sync_r;
    logic          tick_s;
    logic [1:0]    col_idx_r;
    logic [3:0]    col_n_r;
    logic [15:0]   frame_r;
    logic          frame_done_r;
    frame_class_t  cls_r;
    logic          cls_valid_r;
    frame_class_t  cand_r;
    frame_class_t  cand_next_s;
    logic [SW-1:0] stable_r;
    logic [SW-1:0] stable_next_s;
    frame_class_t  acc_r;
    logic          accept_s;
    logic [3:0]    key_code_r;
    logic          key_valid_r;
    logic          key_held_r;

    scan_tick_gen #(.CYCLES(SCAN_TICK_CYC)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= bus.row_n;
            row_sync_r <= row_meta_r;
        end
    end

    // Column stepping and frame capture; the column-3 sample closes a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx_r    <= 2'd0;
            col_n_r      <= COL_PAT[0];
            frame_r      <= 16'h0000;
            frame_done_r <= 1'b0;
        end else if (tick_s) begin
            frame_r[{col_idx_r, 2'b00} +: 4] <= ~row_sync_r;
            col_idx_r    <= col_idx_r + 2'd1;
            col_n_r      <= COL_PAT[col_idx_r + 2'd1];
            frame_done_r <= (col_idx_r == 2'd3);
        end else begin
            frame_done_r <= 1'b0;
        end
    end

    // Frame classification, one cycle after the frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_r       <= CLASS_NONE;
            cls_valid_r <= 1'b0;
        end else begin
            cls_valid_r <= frame_done_r;
            if (frame_done_r) begin
                cls_r <= classify_frame(frame_r);
            end else begin
                cls_r <= cls_r;
            end
        end
    end

    // Next candidate and saturating stable count for this frame's evaluation.
    always_comb begin
        cand_next_s   = cand_r;
        stable_next_s = stable_r;
        if (cls_valid_r) begin
            if (cls_r == cand_r) begin
                if (stable_r < SW'(DEBOUNCE_FRAMES)) begin
                    stable_next_s = stable_r + SW'(1);
                end else begin
                    stable_next_s = stable_r;
                end
            end else begin
                cand_next_s   = cls_r;
                stable_next_s = SW'(1);
            end
        end else begin
            cand_next_s   = cand_r;
            stable_next_s = stable_r;
        end
    end

    assign accept_s = cls_valid_r && (stable_next_s == SW'(DEBOUNCE_FRAMES)) && (cand_next_s != acc_r);

    // Debounce state and accepted-key outputs; MULTI never becomes the accepted state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_r      <= CLASS_NONE;
            stable_r    <= '0;
            acc_r       <= CLASS_NONE;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            cand_r      <= cand_next_s;
            stable_r    <= stable_next_s;
            key_valid_r <= 1'b0;
            if (accept_s) begin
                case (cand_next_s.cls)
                    CLS_KEY: begin
                        acc_r       <= cand_next_s;
                        key_code_r  <= cand_next_s.code;
                        key_held_r  <= 1'b1;
                        key_valid_r <= 1'b1;
                    end
                    CLS_NONE: begin
                        acc_r      <= cand_next_s;
                        key_held_r <= 1'b0;
                    end
                    default: begin
                        acc_r <= acc_r;
                    end
                endcase
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign bus.col_n     = col_n_r;
    assign bus.key_code  = key_code_r;
    assign bus.key_valid = key_valid_r;
    assign bus.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the
// column drive, and a frame-level debounce reference model predicts key events.
module tb_keypad_scanner;
    localparam int TICK  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * TICK;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] mask = 16'h0000;
    logic [3:0]  row_s;
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    keypad_scanner_if bus();

    keypad_scanner #(.SCAN_TICK_CYC(TICK), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pressed key row*4+col pulls row r low while column c is driven low.
    always_comb begin
        row_s = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!bus.col_n[c] && mask[r*4+c]) row_s[r] = 1'b0;
            end
        end
    end
    assign bus.row_n = row_s;

    function automatic logic [3:0] exp_col(input int c);
        logic [3:0] v;
        logic [1:0] i;
        v = 4'b1111;
        i = 2'((c / TICK) % 4);
        v[i] = 1'b0;
        return v;
    endfunction

    // -1 = no key, -2 = several keys, otherwise the key code
    function automatic int frame_class(input logic [15:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        mask = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b expected 1110", bus.col_n); end
        checks++; if (bus.key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d expected 0", bus.key_code); end
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", bus.key_valid); end
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", bus.key_held); end
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            checks++;
            if (bus.col_n !== exp_col(cyc)) begin
                errors++; $display("FAIL idle_col_n: cycle %0d got %b expected %b", cyc, bus.col_n, exp_col(cyc));
            end
            checks++;
            if (bus.key_valid !== 1'b0 || bus.key_held !== 1'b0) begin
                errors++; $display("FAIL idle_outputs: cycle %0d valid=%b held=%b expected 0/0", cyc, bus.key_valid, bus.key_held);
            end
        end
    endtask

    task automatic test_press();
        int pulses;
        int first;
        int t;
        do_reset();
        repeat ($urandom_range(0, 2 * FRAME - 1)) step();
        mask   = 16'h0040;
        pulses = 0;
        first  = -1;
        t      = 0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            step();
            t++;
            if (bus.key_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = t;
                checks++;
                if (bus.key_code !== 4'd6) begin errors++; $display("FAIL press_code: got %0d expected 6", bus.key_code); end
            end
            if (first >= 0) begin
                checks++;
                if (bus.key_held !== 1'b1) begin errors++; $display("FAIL press_held: cycle %0d got %b expected 1", t, bus.key_held); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first < 0 || first > (DEB + 1) * FRAME + 3) begin
            errors++; $display("FAIL press_latency: got %0d cycles expected 1..%0d", first, (DEB + 1) * FRAME + 3);
        end
    endtask

    task automatic test_multi();
        mask = 16'h0240;
        for (int i = 0; i < 6 * FRAME; i++) begin
            step();
            checks++;
            if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL multi_valid: got %b expected 0", bus.key_valid); end
            checks++;
            if (bus.key_held !== 1'b1 || bus.key_code !== 4'd6) begin
                errors++; $display("FAIL multi_state: held=%b code=%0d expected held=1 code=6", bus.key_held, bus.key_code);
            end
        end
    endtask

    task automatic test_release();
        int fall;
        mask = 16'h0000;
        fall = -1;
        for (int i = 1; i <= 8 * FRAME; i++) begin
            step();
            if (fall < 0 && bus.key_held === 1'b0) fall = i;
            checks++;
            if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", bus.key_valid); end
            checks++;
            if (bus.key_code !== 4'd6) begin errors++; $display("FAIL release_code: got %0d expected 6", bus.key_code); end
        end
        checks++;
        if (fall < DEB * FRAME || fall > (DEB + 1) * FRAME + 3) begin
            errors++; $display("FAIL release_delay: held fell after %0d cycles expected %0d..%0d", fall, DEB * FRAME, (DEB + 1) * FRAME + 3);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 10 * FRAME; i++) begin
            mask = (((i / 20) % 2) == 0) ? 16'h0040 : 16'h0000;
            step();
            checks++;
            if (bus.key_valid !== 1'b0 || bus.key_held !== 1'b0) begin
                errors++; $display("FAIL bounce: cycle %0d valid=%b held=%b expected 0/0", cyc, bus.key_valid, bus.key_held);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int first;
        do_reset();
        mask = 16'h0040;
        repeat (4 * FRAME) step();
        checks++;
        if (bus.key_held !== 1'b1 || bus.key_code !== 4'd6) begin
            errors++; $display("FAIL mid_pre: held=%b code=%0d expected held=1 code=6", bus.key_held, bus.key_code);
        end
        mask = 16'h0008;
        for (int i = 0; i < FRAME + 5; i++) begin
            step();
            checks++;
            if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL mid_early_valid: cycle %0d got 1 expected 0", cyc); end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.col_n !== 4'b1110) begin errors++; $display("FAIL mid_col_n: got %b expected 1110", bus.col_n); end
        checks++; if (bus.key_code !== 4'd0) begin errors++; $display("FAIL mid_code: got %0d expected 0", bus.key_code); end
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("FAIL mid_held: got %b expected 0", bus.key_held); end
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.key_valid); end
        @(negedge clk);
        rst    = 1'b0;
        cyc    = 0;
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 5 * FRAME; i++) begin
            step();
            if (bus.key_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
                checks++;
                if (bus.key_code !== 4'd3) begin errors++; $display("FAIL mid_key_code: got %0d expected 3", bus.key_code); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL mid_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first < DEB * FRAME || first > (DEB + 1) * FRAME + 3) begin
            errors++; $display("FAIL mid_latency: pulse at cycle %0d expected %0d..%0d", first, DEB * FRAME, (DEB + 1) * FRAME + 3);
        end
    endtask

    task automatic test_random();
        int hist[$];
        int acc;
        int exp_code;
        int exp_held;
        int exp_pulse;
        int hold;
        int pulses;
        int c;
        int sel;
        int a;
        int b;
        bit same;
        do_reset();
        acc       = -1;
        exp_code  = 0;
        exp_held  = 0;
        exp_pulse = 0;
        hold      = 0;
        for (int k = 0; k < 80; k++) begin
            if (hold == 0) begin
                sel  = $urandom_range(0, 3);
                a    = $urandom_range(0, 15);
                b    = (a + $urandom_range(1, 15)) % 16;
                mask = 16'h0000;
                if (sel == 1 || sel == 2) mask[a] = 1'b1;
                if (sel == 3) begin mask[a] = 1'b1; mask[b] = 1'b1; end
                hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 6);
            end
            hold--;
            pulses = 0;
            for (int i = 0; i < FRAME; i++) begin
                step();
                checks++;
                if (bus.col_n !== exp_col(cyc)) begin
                    errors++; $display("FAIL rand_col_n: cycle %0d got %b expected %b", cyc, bus.col_n, exp_col(cyc));
                end
                if (bus.key_valid === 1'b1) pulses++;
            end
            checks++;
            if (pulses != exp_pulse) begin errors++; $display("FAIL rand_pulses: frame %0d got %0d expected %0d", k, pulses, exp_pulse); end
            checks++;
            if (bus.key_code !== 4'(exp_code)) begin errors++; $display("FAIL rand_code: frame %0d got %0d expected %0d", k, bus.key_code, exp_code); end
            checks++;
            if (bus.key_held !== 1'(exp_held)) begin errors++; $display("FAIL rand_held: frame %0d got %b expected %0d", k, bus.key_held, exp_held); end
            // reference: accept once the last DEB frames agree on something new
            c = frame_class(mask);
            hist.push_back(c);
            if (hist.size() > DEB) void'(hist.pop_front());
            same = (hist.size() == DEB);
            foreach (hist[j]) if (hist[j] != c) same = 1'b0;
            exp_pulse = 0;
            if (same && c != acc && c != -2) begin
                acc = c;
                if (c >= 0) begin
                    exp_code  = c;
                    exp_held  = 1;
                    exp_pulse = 1;
                end else begin
                    exp_held = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_multi();
        test_release();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 matrix keypad used to set alarm and clock digits.
- Drives one column low at a time, samples the rows, and debounces over whole scan frames.
- Reports each accepted press as a one-cycle strobe with a 4-bit key code.
- Runs on the same 50 MHz clock as the display; its 1 ms column period matches the display digit period.

Parameters:
- SCAN_TICK_CYC, 50000: clock cycles per column slot; must be >= 4.
- DEBOUNCE_FRAMES, 20: consecutive identical frames needed to accept a change; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_n  output  4  column drive, active-low, exactly one bit low at all times
- key_code  output  4  code of last accepted key: row_index*4 + col_index
- key_valid  output  1  one-cycle pulse when a new key press is accepted
- key_held  output  1  high while the accepted state is a pressed key

Behaviour:
- Reset values:
  - col_n = 4'b1110; key_code = 0; key_valid = 0; key_held = 0.
  - Tick counter = 0; column index = 0; frame register cleared.
  - Candidate = NONE; stable count = 0; accepted state = NONE.
- Row synchronization: row_n passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Column scan:
  - Tick counter runs 0..SCAN_TICK_CYC-1 and wraps.
  - When count == SCAN_TICK_CYC-1: sample the inverted synchronized rows into frame bits [col*4 +: 4], then advance the column index (3 wraps to 0).
  - col_n is registered: column 0 = 1110, 1 = 1101, 2 = 1011, 3 = 0111.
  - Period per column = SCAN_TICK_CYC cycles; frame = 4*SCAN_TICK_CYC cycles.
- Frame classification, registered in the cycle after the column-3 sample:
  - Zero bits set gives NONE.
  - Exactly one bit set gives KEY(code).
  - Two or more bits set gives MULTI.
- Debounce, evaluated once per frame:
  - If the class equals the candidate, stable count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise candidate = class and stable count = 1.
- Acceptance happens in the same evaluation when stable count reaches DEBOUNCE_FRAMES and the candidate differs from the accepted state:
  - KEY(c): accepted = KEY(c); key_code = c; key_held = 1; key_valid pulses for exactly one cycle, coincident with the key_code update.
  - NONE: accepted = NONE; key_held = 0; key_code holds its last value; no pulse.
  - MULTI: ignored; accepted state, key_code and key_held are unchanged; no pulse.
- Holding a key produces exactly one pulse; there is no auto-repeat.
- A direct transition KEY(a) -> KEY(b) with b != a, stable for DEBOUNCE_FRAMES frames, produces a pulse for b.
- Latency from a clean press to key_valid: at most (DEBOUNCE_FRAMES+1)*4*SCAN_TICK_CYC + 3 cycles.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - No pulse is produced by the partial frame.
  - Scanning restarts at column 0.

Decomposition:
- Shared package alarm_pkg holds:
  - Column drive patterns COL_PAT[0..3].
  - Frame class encoding CLS_NONE / CLS_KEY / CLS_MULTI.
  - Key-code constants for the logical legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D mapped to codes 0..15.
  - A function mapping key code to decimal digit value, returning 4'hF for non-digit keys.
- One sub-module: scan_tick_gen, a parameterized cycle divider producing a one-cycle tick every SCAN_TICK_CYC cycles.
  - It is reused for column stepping and is a candidate to replace the display's ad-hoc divider.

Test Plan (SCAN_TICK_CYC=4, DEBOUNCE_FRAMES=3, frame = 16 cycles):
- Reset, no keys -> col_n = 1110 in cycles 0-3, 1101 in 4-7, 1011 in 8-11, 0111 in 12-15, repeating; key_valid never asserts; key_held = 0.
- Hold row 1 low whenever col_n[2] is low, for 8 frames -> exactly one key_valid pulse with key_code = 6, within 67 cycles of the press; key_held = 1 from that pulse onward.
- Bounce: toggle the code-6 press every 20 cycles for 10 frames -> no key_valid; key_held stays 0.
- After an accepted code 6, release -> key_held falls 3-4 frames later; no key_valid; key_code stays 6.
- Press codes 6 and 9 together for 6 frames -> no key_valid; key_held and key_code unchanged.
- Assert rst for 1 cycle during the second stable frame of a code-3 press, then keep the key held -> outputs return to reset values immediately; key_valid pulses with key_code = 3 only after 3 full frames following reset release.
